// File: rtl/prism_sp_fifo_pkt_reader_if.sv
// FIFO read port and output stream bundle for the SP puzzle FIFO packet reader.
// The reader drives the master modport; the FIFO and stream consumer sit on the slave side.
interface prism_sp_fifo_pkt_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/prism_sp_fifo_pkt_reader.sv
// Drains length-prefixed packets from an FWFT FIFO and presents the payload as a
// valid/ready stream with last; the header word is consumed and not forwarded.
module prism_sp_fifo_pkt_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_LEN    = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  prism_sp_fifo_pkt_reader_if.master  bus,
  output logic                        busy,
  output logic                        err_zero_len,
  output logic                        err_oversize,
  output logic [31:0]                 pkt_count
);

  typedef enum logic {S_HDR, S_DATA} state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 pop;
  logic                 xfer;

  assign hdr_len = bus.fifo_rd_data[LEN_WIDTH-1:0];
  assign xfer    = bus.m_valid && bus.m_ready;

  // Headers pop freely; payload pops only when the output register is free or draining.
  assign pop = !bus.fifo_empty && ((state == S_HDR) || !bus.m_valid || bus.m_ready);
  assign bus.fifo_rd_en = pop;
  assign busy = (state != S_HDR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_HDR;
      remaining    <= '0;
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.m_last   <= 1'b0;
      err_zero_len <= 1'b0;
      err_oversize <= 1'b0;
      pkt_count    <= '0;
    end else begin
      err_zero_len <= 1'b0;
      err_oversize <= 1'b0;

      if (xfer) begin
        bus.m_valid <= 1'b0;
        if (bus.m_last) begin
          pkt_count <= pkt_count + 32'd1;
        end
      end

      case (state)
        S_HDR: begin
          if (pop) begin
            if (hdr_len == '0) begin
              err_zero_len <= 1'b1;
            end else if (hdr_len > MAX_LEN_L) begin
              err_oversize <= 1'b1;
            end else begin
              remaining <= hdr_len;
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (pop) begin
            // A pop in the same cycle as a transfer reloads the register back-to-back.
            bus.m_data  <= bus.fifo_rd_data;
            bus.m_valid <= 1'b1;
            bus.m_last  <= (remaining == LEN_ONE);
            remaining   <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_HDR;
            end
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_prism_sp_fifo_pkt_reader.sv
// Directed and scoreboarded checks for the SP FIFO packet reader, with a
// behavioural FWFT FIFO on the read side and a capturing stream consumer.
module tb_prism_sp_fifo_pkt_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 16;
  localparam int unsigned MAXL  = 1024;
  localparam int          DEPTH = 4096;

  logic        clock;
  logic        reset;
  logic        busy;
  logic        err_zero_len;
  logic        err_oversize;
  logic [31:0] pkt_count;

  prism_sp_fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus ();

  prism_sp_fifo_pkt_reader #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_LEN(MAXL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .err_zero_len (err_zero_len),
    .err_oversize (err_oversize),
    .pkt_count    (pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural FWFT FIFO; pointers only advance on clock edges.
  logic [DW-1:0] mem [DEPTH];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          ready_val = 1'b1;
  logic          rand_mode = 1'b0;
  logic          rnd_ready = 1'b1;
  logic          rnd_empty = 1'b0;

  assign bus.fifo_rd_data = mem[rd_ptr % DEPTH];
  assign bus.fifo_empty   = (rd_ptr == wr_ptr) || (rand_mode && rnd_empty);
  assign bus.m_ready      = rand_mode ? rnd_ready : ready_val;

  always @(negedge clock) begin
    rnd_ready = ($urandom_range(0, 3) != 0);
    rnd_empty = ($urandom_range(0, 4) == 0);
  end

  always @(posedge clock) begin
    if (reset) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en && !bus.fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr++;
  endtask

  // Stream monitor: pre-edge values are read at the edge, before the DUT updates.
  logic [32:0] cap_q [$];
  int          cap_cyc [$];
  int          cyc = 0;
  int          pop_viol = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en && bus.fifo_empty) pop_viol++;
    if (!reset) begin
      if (prev_stall && (!bus.m_valid || bus.m_data != prev_data || bus.m_last != prev_last))
        stall_viol++;
      if (busy && bus.m_valid && !bus.m_ready && bus.fifo_rd_en) stall_viol++;
      if (bus.m_valid && bus.m_ready) begin
        cap_q.push_back({bus.m_last, bus.m_data});
        cap_cyc.push_back(cyc);
      end
    end
    prev_stall = !reset && bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
  end

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int t = 0;
    while (cap_q.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_eq({tag, "_done"}, 64'(cap_q.size() >= n), 64'd1);
  endtask

  logic [32:0] exp_q [$];
  int          base;
  int          k;
  int          n_last;
  logic [31:0] exp_pkt;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("rst_last",  64'(bus.m_last),  64'd0);
    check_eq("rst_data",  64'(bus.m_data),  64'd0);
    check_eq("rst_busy",  64'(busy),        64'd0);
    check_eq("rst_errs",  64'({err_zero_len, err_oversize}), 64'd0);
    check_eq("rst_pkt",   64'(pkt_count),   64'd0);
    check_eq("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // T1: one 3-word packet at full rate
    base = cap_q.size();
    k = cyc;
    push(32'd3); push(32'hA0A0_0001); push(32'hB0B0_0002); push(32'hC0C0_0003);
    wait_xfers("t1", base + 3, 50);
    check_eq("t1_a",     64'(cap_q[base]),       {31'd0, 1'b0, 32'hA0A0_0001});
    check_eq("t1_b",     64'(cap_q[base+1]),     {31'd0, 1'b0, 32'hB0B0_0002});
    check_eq("t1_c",     64'(cap_q[base+2]),     {31'd0, 1'b1, 32'hC0C0_0003});
    check_eq("t1_cyc_a", 64'(cap_cyc[base]),     64'(k + 2));
    check_eq("t1_cyc_c", 64'(cap_cyc[base+2]),   64'(k + 4));
    check_eq("t1_pkt",   64'(pkt_count),         64'd1);

    // T2: back-to-back packets; one bubble for the second header
    base = cap_q.size();
    k = cyc;
    push(32'd1); push(32'h1111_0000); push(32'd2); push(32'h2222_0000); push(32'h3333_0000);
    wait_xfers("t2", base + 3, 50);
    check_eq("t2_x",     64'(cap_q[base]),     {31'd0, 1'b1, 32'h1111_0000});
    check_eq("t2_y",     64'(cap_q[base+1]),   {31'd0, 1'b0, 32'h2222_0000});
    check_eq("t2_z",     64'(cap_q[base+2]),   {31'd0, 1'b1, 32'h3333_0000});
    check_eq("t2_cyc_x", 64'(cap_cyc[base]),   64'(k + 2));
    check_eq("t2_cyc_y", 64'(cap_cyc[base+1]), 64'(k + 4));
    check_eq("t2_cyc_z", 64'(cap_cyc[base+2]), 64'(k + 5));
    check_eq("t2_pkt",   64'(pkt_count),       64'd3);

    // T3: consumer stall holds data and blocks pops
    ready_val = 1'b0;
    base = cap_q.size();
    push(32'd4);
    for (int i = 0; i < 4; i++) push(32'hD000_0000 + 32'(i));
    begin
      int t = 0;
      while (!bus.m_valid && t < 20) begin
        @(negedge clock);
        t++;
      end
    end
    check_eq("t3_valid", 64'(bus.m_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_data", 64'(bus.m_data),     64'hD000_0000);
      check_eq("t3_hold_pop",  64'(bus.fifo_rd_en), 64'd0);
      @(negedge clock);
    end
    ready_val = 1'b1;
    wait_xfers("t3", base + 4, 50);
    for (int i = 0; i < 4; i++)
      check_eq("t3_word", 64'(cap_q[base+i]), {31'd0, (i == 3), 32'hD000_0000 + 32'(i)});
    check_eq("t3_pkt", 64'(pkt_count), 64'd4);

    // T4: zero-length and oversize headers are dropped; upper header bits ignored
    base = cap_q.size();
    push(32'd0); push(32'd2000); push(32'd1025); push(32'hABCD_0001); push(32'h5151_5151);
    @(negedge clock);
    check_eq("t4_zero_pulse", 64'({err_zero_len, err_oversize}), 64'b10);
    @(negedge clock);
    check_eq("t4_over_pulse", 64'({err_zero_len, err_oversize}), 64'b01);
    @(negedge clock);
    check_eq("t4_over_1025",  64'({err_zero_len, err_oversize}), 64'b01);
    @(negedge clock);
    check_eq("t4_pulse_end",  64'({err_zero_len, err_oversize}), 64'b00);
    check_eq("t4_busy",       64'(busy), 64'd1);
    wait_xfers("t4", base + 1, 50);
    check_eq("t4_q",   64'(cap_q[base]), {31'd0, 1'b1, 32'h5151_5151});
    check_eq("t4_pkt", 64'(pkt_count),   64'd5);

    // MAX_LEN itself is accepted
    base = cap_q.size();
    push(32'd1024);
    for (int i = 0; i < 1024; i++) push(32'h7000_0000 + 32'(i));
    wait_xfers("tmax", base + 1024, 3000);
    n_last = 0;
    for (int i = 0; i < 1024; i++) n_last += int'(cap_q[base+i][32]);
    check_eq("tmax_nlast", 64'(n_last), 64'd1);
    check_eq("tmax_final", 64'(cap_q[base+1023]), {31'd0, 1'b1, 32'h7000_03FF});
    check_eq("tmax_pkt",   64'(pkt_count), 64'd6);

    // T5: reset mid-packet abandons it
    base = cap_q.size();
    push(32'd5);
    for (int i = 0; i < 5; i++) push(32'hE000_0000 + 32'(i));
    wait_xfers("t5a", base + 2, 50);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_valid", 64'(bus.m_valid), 64'd0);
    check_eq("t5_last",  64'(bus.m_last),  64'd0);
    check_eq("t5_data",  64'(bus.m_data),  64'd0);
    check_eq("t5_busy",  64'(busy),        64'd0);
    check_eq("t5_pkt0",  64'(pkt_count),   64'd0);
    reset = 1'b0;
    @(negedge clock);
    base = cap_q.size();
    push(32'd1); push(32'h5757_0001);
    wait_xfers("t5b", base + 1, 50);
    check_eq("t5_w",   64'(cap_q[base]), {31'd0, 1'b1, 32'h5757_0001});
    check_eq("t5_pkt", 64'(pkt_count),   64'd1);

    // T6: FIFO runs dry mid-packet
    base = cap_q.size();
    push(32'd3); push(32'h6000_0000);
    wait_xfers("t6a", base + 1, 50);
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_gap_valid", 64'(bus.m_valid), 64'd0);
      check_eq("t6_gap_busy",  64'(busy),        64'd1);
      @(negedge clock);
    end
    push(32'h6000_0001); push(32'h6000_0002);
    wait_xfers("t6b", base + 3, 50);
    for (int i = 0; i < 3; i++)
      check_eq("t6_word", 64'(cap_q[base+i]), {31'd0, (i == 2), 32'h6000_0000 + 32'(i)});
    check_eq("t6_pkt", 64'(pkt_count), 64'd2);

    // Random ready and FIFO starvation over 1000 packets against a scoreboard
    exp_pkt = pkt_count + 32'd1000;
    base = cap_q.size();
    exp_q.delete();
    rand_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      int t;
      len = $urandom_range(1, 4);
      t = 0;
      while ((wr_ptr - rd_ptr) >= 32 && t < 500) begin
        @(negedge clock);
        t++;
      end
      push({16'($urandom), 16'(len)});
      for (int j = 0; j < len; j++) begin
        logic [31:0] w;
        w = $urandom;
        push(w);
        exp_q.push_back({(j == len - 1), w});
      end
    end
    wait_xfers("rnd", base + exp_q.size(), 20000);
    rand_mode = 1'b0;
    begin
      int n_bad;
      n_bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (base + i >= cap_q.size() || cap_q[base+i] !== exp_q[i]) begin
          if (n_bad < 5) check_eq("rnd_word", 64'(cap_q[base+i]), 64'(exp_q[i]));
          n_bad++;
        end
      end
      check_eq("rnd_bad_words", 64'(n_bad), 64'd0);
    end
    check_eq("rnd_count", 64'(cap_q.size() - base), 64'(exp_q.size()));
    check_eq("rnd_pkt",   64'(pkt_count), 64'(exp_pkt));

    repeat (2) @(negedge clock);
    check_eq("pop_under_empty", 64'(pop_viol),   64'd0);
    check_eq("stall_stable",    64'(stall_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
